dcache_ctrl: RTL

Direct-mapped, write-through, no-write-allocate data cache between the multi-cycle control/datapath and main data memory. It accepts one load or store at a time via the `MemRead`/`MemWrite`/`Cache_RDY`/`Cache_VALID` handshake. On a read miss it refills a 4-word line from memory. Every store is forwarded to memory and completes only when memory acknowledges it.

---
 rtl/dcache_ctrl_if.sv | 37 +++
 rtl/dcache_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: the bus bundle around dcache_ctrl.
//   CPU side : ADDR, WDATA, BE, MemRead, MemWrite   -> cache
//              RDATA, Cache_RDY, Cache_VALID         <- cache
//   Mem side : MEM_REQ, MEM_WEN, MEM_ADDR,
//              MEM_WDATA, MEM_BE                     <- cache
//              MEM_RDATA, MEM_ACK                    -> cache
// The slave modport is the cache's view.
// The master modport is the environment's view (CPU plus memory).
interface dcache_ctrl_if;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [3:0]  BE;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] RDATA;
  logic        Cache_RDY;
  logic        Cache_VALID;
  logic        MEM_REQ;
  logic        MEM_WEN;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport slave (
    input  ADDR, WDATA, BE, MemRead, MemWrite, MEM_RDATA, MEM_ACK,
    output RDATA, Cache_RDY, Cache_VALID,
           MEM_REQ, MEM_WEN, MEM_ADDR, MEM_WDATA, MEM_BE
  );

  modport master (
    output ADDR, WDATA, BE, MemRead, MemWrite, MEM_RDATA, MEM_ACK,
    input  RDATA, Cache_RDY, Cache_VALID,
           MEM_REQ, MEM_WEN, MEM_ADDR, MEM_WDATA, MEM_BE
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
// Lines are 4 words. A read miss refills the whole line. Every store is
// forwarded to memory and completes on MEM_ACK.
// Ports:
//   CLK  : clock; all state changes on the rising edge
//   RST  : synchronous, active-high reset
//   bus  : dcache_ctrl_if.slave
//          CPU request/response and memory request/ack signals
module dcache_ctrl #(
  parameter int unsigned NUM_LINES = 8
) (
  input logic         CLK,
  input logic         RST,
  dcache_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRMEM, RESP} state_t;

  state_t            r_state;
  logic              r_armed;
  logic [31:2]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_wr;
  logic [1:0]        r_cnt;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag  [NUM_LINES];
  logic [31:0]       r_data [NUM_LINES][4];

  logic              r_rdy;
  logic              r_cvalid;
  logic              r_mreq;
  logic              r_mwen;
  logic [31:0]       r_maddr;
  logic [31:0]       r_mwdata;
  logic [3:0]        r_mbe;
  logic [31:0]       r_rdata;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_word;
  logic [31:0]       w_cur;
  logic [31:0]       w_merged;
  logic              w_hit;
  logic              w_req;
  logic              w_unused_addr_lsb;

  assign w_idx  = r_addr[3+IDX_W:4];
  assign w_tag  = r_addr[31:4+IDX_W];
  assign w_word = r_addr[3:2];
  assign w_cur  = r_data[w_idx][w_word];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_req  = bus.MemRead | bus.MemWrite;
  assign w_unused_addr_lsb = ^bus.ADDR[1:0];

  always_comb begin
    w_merged = w_cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (r_be[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_armed  <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_valid  <= '0;
      r_rdy    <= 1'b0;
      r_cvalid <= 1'b0;
      r_mreq   <= 1'b0;
      r_mwen   <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_mbe    <= '0;
      r_rdata  <= '0;
    end else begin
      // A request level still held after completion must drop once
      // before it can be accepted again.
      if (!w_req) r_armed <= 1'b1;

      unique case (r_state)
        IDLE: begin
          if (r_rdy && r_armed && w_req) begin
            r_addr  <= bus.ADDR[31:2];
            r_wdata <= bus.WDATA;
            r_be    <= bus.BE;
            r_wr    <= bus.MemWrite;
            r_armed <= 1'b0;
            r_rdy   <= 1'b0;
            r_state <= LOOKUP;
          end else begin
            r_rdy <= 1'b1;
          end
        end

        LOOKUP: begin
          if (r_wr) begin
            if (w_hit) r_data[w_idx][w_word] <= w_merged;
            r_mreq   <= 1'b1;
            r_mwen   <= 1'b1;
            r_maddr  <= {r_addr[31:2], 2'b00};
            r_mwdata <= r_wdata;
            r_mbe    <= r_be;
            r_state  <= WRMEM;
          end else if (w_hit) begin
            r_rdata  <= w_cur;
            r_cvalid <= 1'b1;
            r_state  <= RESP;
          end else begin
            r_cnt   <= '0;
            r_mreq  <= 1'b1;
            r_mwen  <= 1'b0;
            r_maddr <= {r_addr[31:4], 4'b0000};
            r_mbe   <= '1;
            r_state <= REFILL;
          end
        end

        REFILL: begin
          if (bus.MEM_ACK) begin
            r_data[w_idx][r_cnt] <= bus.MEM_RDATA;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_tag[w_idx]   <= w_tag;
              r_valid[w_idx] <= 1'b1;
              r_mreq         <= 1'b0;
              // Earlier words are already in the array; the last word is
              // only on the memory bus this cycle.
              r_rdata  <= (w_word == 2'd3) ? bus.MEM_RDATA : w_cur;
              r_cvalid <= 1'b1;
              r_state  <= RESP;
            end else begin
              r_maddr <= {r_addr[31:4], r_cnt + 2'd1, 2'b00};
            end
          end
        end

        WRMEM: begin
          if (bus.MEM_ACK) begin
            r_mreq   <= 1'b0;
            r_mwen   <= 1'b0;
            r_cvalid <= 1'b1;
            r_state  <= RESP;
          end
        end

        RESP: begin
          r_cvalid <= 1'b0;
          r_rdy    <= 1'b1;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.RDATA       = r_rdata;
  assign bus.Cache_RDY   = r_rdy;
  assign bus.Cache_VALID = r_cvalid;
  assign bus.MEM_REQ     = r_mreq;
  assign bus.MEM_WEN     = r_mwen;
  assign bus.MEM_ADDR    = r_maddr;
  assign bus.MEM_WDATA   = r_mwdata;
  assign bus.MEM_BE      = r_mbe;
endmodule
